memory_dp: RTL

//   Parametrised simple-dual-port word memory: one write port, one read port, one clock.

---
 rtl/memory_dp_if.sv | 26 ++
 rtl/memory_dp.sv | 137 +++++++++++++
 2 files changed

// File: rtl/memory_dp_if.sv
// Request/response bundle of the simple-dual-port memory: one write channel,
// one read channel and the ready flag raised once the post-reset clear is done.
interface memory_dp_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                    in_en;
   logic [ADDR_WIDTH-1:0]   in_addr;
   logic [DATA_WIDTH-1:0]   in_data;
   logic [DATA_WIDTH/8-1:0] in_mask;
   logic                    out_en;
   logic [ADDR_WIDTH-1:0]   out_addr;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_valid;
   logic                    ready;

   modport master (
      output in_en, in_addr, in_data, in_mask, out_en, out_addr,
      input  out_data, out_valid, ready
   );

   modport slave (
      input  in_en, in_addr, in_data, in_mask, out_en, out_addr,
      output out_data, out_valid, ready
   );
endinterface

// File: rtl/memory_dp.sv
// Simple-dual-port word memory with byte write mask, pipelined read with valid
// strobe, selectable read-during-write behaviour and optional clear after reset.
module memory_dp #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,
   memory_dp_if.slave  bus
);
   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
   logic                    ready_reg;
   logic                    rd_valid_reg;

   logic                    clearing;
   logic                    wr_fire;
   logic                    rd_fire;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   rd_word;

   // The clear sweep owns the write port; user requests only count once ready.
   assign clearing = (state_reg == ST_CLEAR) && !rst;
   assign wr_fire  = ready_reg && !rst && bus.in_en;
   assign rd_fire  = ready_reg && bus.out_en;
   assign wr_addr  = clearing ? clr_cnt_reg : bus.in_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_reg <= '0;
         ready_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_CLEAR: begin
               clr_cnt_reg <= clr_cnt_reg + ADDR_WIDTH'(1);
               if (clr_cnt_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_reg <= ST_RUN;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   genvar gi;
   generate
      // One narrow RAM per byte lane keeps the masked write a plain write enable.
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_byte_reg;
         logic       wr_lane;
         logic [7:0] wr_byte;

         assign wr_lane = clearing || (wr_fire && bus.in_mask[gi]);
         assign wr_byte = clearing ? 8'h00 : bus.in_data[gi*8 +: 8];

         always_ff @(posedge clk) begin
            if (wr_lane) begin
               lane_mem[wr_addr] <= wr_byte;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_byte_reg <= '0;
            end else if (rd_fire) begin
               if (RDW_MODE != 0 && wr_lane && wr_addr == bus.out_addr) begin
                  rd_byte_reg <= wr_byte;
               end else begin
                  rd_byte_reg <= lane_mem[bus.out_addr];
               end
            end
         end

         assign rd_word[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_fire;
      end
   end

   generate
      if (READ_LATENCY <= 1) begin : g_lat1
         assign bus.out_data  = rd_word;
         assign bus.out_valid = rd_valid_reg;
      end else begin : g_latn
         // Extra stages only advance on a valid word so out_data holds between reads.
         logic [DATA_WIDTH-1:0] dly_data_reg  [READ_LATENCY-1];
         logic                  dly_valid_reg [READ_LATENCY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < READ_LATENCY - 1; k++) begin
                  dly_data_reg[k]  <= '0;
                  dly_valid_reg[k] <= 1'b0;
               end
            end else begin
               dly_valid_reg[0] <= rd_valid_reg;
               if (rd_valid_reg) begin
                  dly_data_reg[0] <= rd_word;
               end
               for (int k = 1; k < READ_LATENCY - 1; k++) begin
                  dly_valid_reg[k] <= dly_valid_reg[k-1];
                  if (dly_valid_reg[k-1]) begin
                     dly_data_reg[k] <= dly_data_reg[k-1];
                  end
               end
            end
         end

         assign bus.out_data  = dly_data_reg[READ_LATENCY-2];
         assign bus.out_valid = dly_valid_reg[READ_LATENCY-2];
      end
   endgenerate

   assign bus.ready = ready_reg;
endmodule
